// File: rtl/word_line_merger_pkg.sv
// Shared definitions for the cache-line word extractor/merger pair:
// FSM state encodings, bus-width derivations and the byte-offset to word-index rule.
package word_line_merger_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MERGE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int BYTE_BITS     = 8;
    localparam int SEL_BYTE_BITS = 2;

    function automatic int be_width(input int word_width);
        return word_width / BYTE_BITS;
    endfunction

    function automatic int str_width(input int word_width, input int word_count);
        return word_width * word_count;
    endfunction

    // Byte offset to word index; the low byte-within-word bits are dropped.
    function automatic int unsigned word_index(input int unsigned sel);
        return sel >> SEL_BYTE_BITS;
    endfunction

endpackage

// File: rtl/word_inserter.sv
// Replaces the enabled bytes of one word of a line; inverse of the word extractor.
// Latency: combinational. Backpressure: none, pure datapath.
// Unselected words and disabled bytes pass through unchanged.
module word_inserter
    import word_line_merger_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int WORD_COUNT = 4,
    parameter int IDX_WIDTH  = 2,
    localparam int STR_WIDTH = str_width(WORD_WIDTH, WORD_COUNT),
    localparam int BE_WIDTH  = be_width(WORD_WIDTH)
) (
    input  logic [STR_WIDTH-1:0]  line_in,
    input  logic [IDX_WIDTH-1:0]  idx,
    input  logic [WORD_WIDTH-1:0] data,
    input  logic [BE_WIDTH-1:0]   be,
    output logic [STR_WIDTH-1:0]  line_out
);

    always_comb begin
        line_out = line_in;
        for (int w = 0; w < WORD_COUNT; w++) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if ((idx == IDX_WIDTH'(w)) && be[k]) begin
                    line_out[w*WORD_WIDTH + k*BYTE_BITS +: BYTE_BITS] = data[k*BYTE_BITS +: BYTE_BITS];
                end
            end
        end
    end

endmodule

// File: rtl/word_line_merger.sv
// Holds one cache line, merges byte-masked word writes, emits the line with a per-word dirty mask.
// Latency: load->write ready 1 cycle, flush->line_valid 1 cycle, drain->load_ready 1 cycle.
// Backpressure: line_out/line_dirty held while line_ready is low; writes and loads stall meanwhile.
module word_line_merger
    import word_line_merger_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int WORD_COUNT = 4,
    parameter int SEL_WIDTH  = 4,
    localparam int STR_WIDTH = str_width(WORD_WIDTH, WORD_COUNT),
    localparam int BE_WIDTH  = be_width(WORD_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic [STR_WIDTH-1:0]  load_line,
    output logic                  load_ready,
    input  logic                  wr_valid,
    input  logic [SEL_WIDTH-1:0]  wr_sel,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_be,
    output logic                  wr_ready,
    input  logic                  flush,
    output logic                  line_valid,
    output logic [STR_WIDTH-1:0]  line_out,
    output logic [WORD_COUNT-1:0] line_dirty,
    input  logic                  line_ready
);

    localparam int IDX_WIDTH = SEL_WIDTH - SEL_BYTE_BITS;

    state_t                state_q;
    state_t                state_d;
    logic [STR_WIDTH-1:0]  buf_q;
    logic [WORD_COUNT-1:0] dirty_q;
    logic [STR_WIDTH-1:0]  merged_line;
    logic [IDX_WIDTH-1:0]  wr_idx;
    logic                  load_fire;
    logic                  wr_fire;
    logic                  drain_fire;

    assign wr_idx = IDX_WIDTH'(word_index(32'(wr_sel)));

    word_inserter #(
        .WORD_WIDTH (WORD_WIDTH),
        .WORD_COUNT (WORD_COUNT),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_word_inserter (
        .line_in  (buf_q),
        .idx      (wr_idx),
        .data     (wr_data),
        .be       (wr_be),
        .line_out (merged_line)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshakes decode only from state and rst, so no input reaches an output combinationally.
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        wr_ready   = 1'b0;
        line_valid = 1'b0;
        load_fire  = 1'b0;
        wr_fire    = 1'b0;
        drain_fire = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_EMPTY: begin
                    load_ready = 1'b1;
                    if (load_valid) begin
                        load_fire = 1'b1;
                        state_d   = ST_MERGE;
                    end
                end
                ST_MERGE: begin
                    wr_ready = 1'b1;
                    wr_fire  = wr_valid;
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    line_valid = 1'b1;
                    if (line_ready) begin
                        drain_fire = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // A write coinciding with flush still lands here, so it is part of the emitted line.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            dirty_q <= '0;
        end else if (load_fire) begin
            buf_q   <= load_line;
            dirty_q <= '0;
        end else if (wr_fire) begin
            buf_q           <= merged_line;
            dirty_q[wr_idx] <= dirty_q[wr_idx] | (|wr_be);
        end else if (drain_fire) begin
            dirty_q <= '0;
        end
    end

    assign line_out   = buf_q;
    assign line_dirty = dirty_q;

endmodule

// File: tb/tb_word_line_merger.sv
// Self-checking bench for word_line_merger: vector table, corner-case sequences, random sessions.
module tb_word_line_merger;

    localparam logic [127:0] BASE = 128'h33333333_22222222_11111111_00000000;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_valid;
    logic [127:0] load_line;
    logic         load_ready;
    logic         wr_valid;
    logic [3:0]   wr_sel;
    logic [31:0]  wr_data;
    logic [3:0]   wr_be;
    logic         wr_ready;
    logic         flush;
    logic         line_valid;
    logic [127:0] line_out;
    logic [3:0]   line_dirty;
    logic         line_ready;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    word_line_merger dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_line  (load_line),
        .load_ready (load_ready),
        .wr_valid   (wr_valid),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .wr_be      (wr_be),
        .wr_ready   (wr_ready),
        .flush      (flush),
        .line_valid (line_valid),
        .line_out   (line_out),
        .line_dirty (line_dirty),
        .line_ready (line_ready)
    );

    typedef struct {
        logic [3:0]   sel;
        logic [31:0]  data;
        logic [3:0]   be;
        logic [127:0] exp_line;
        logic [3:0]   exp_dirty;
    } vec_t;

    vec_t vecs[6];

    // Reference model: the line as a plain byte array plus one dirty flag per word.
    logic [7:0] mb[16];
    logic [3:0] md;

    function automatic logic [127:0] model_line();
        logic [127:0] l;
        for (int b = 0; b < 16; b++) l[b*8 +: 8] = mb[b];
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic do_load(input logic [127:0] l);
        load_valid = 1'b1;
        load_line  = l;
        tick();
        load_valid = 1'b0;
        chk("wr_ready_after_load", wr_ready, 1);
    endtask

    task automatic do_write(input logic [3:0] s, input logic [31:0] d, input logic [3:0] b, input logic fl);
        wr_valid = 1'b1;
        wr_sel   = s;
        wr_data  = d;
        wr_be    = b;
        flush    = fl;
        tick();
        wr_valid = 1'b0;
        wr_be    = 4'h0;
        flush    = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("line_valid_after_flush", line_valid, 1);
    endtask

    task automatic do_drain(input string nm, input logic [127:0] el, input logic [3:0] ed);
        chk({nm, "_line"}, line_out, el);
        chk({nm, "_dirty"}, line_dirty, ed);
        line_ready = 1'b1;
        tick();
        line_ready = 1'b0;
        chk({nm, "_load_ready_after"}, load_ready, 1);
        chk({nm, "_valid_dropped"}, line_valid, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{4'h8, 32'hAABBCCDD, 4'hF, 128'h33333333_AABBCCDD_11111111_00000000, 4'b0100};
        vecs[1] = '{4'h5, 32'h000000EE, 4'h1, 128'h33333333_22222222_111111EE_00000000, 4'b0010};
        vecs[2] = '{4'hF, 32'h12345678, 4'hF, 128'h12345678_22222222_11111111_00000000, 4'b1000};
        vecs[3] = '{4'h0, 32'hDEADBEEF, 4'h0, BASE, 4'b0000};
        vecs[4] = '{4'h3, 32'hCAFEF00D, 4'hA, 128'h33333333_22222222_11111111_CA00F000, 4'b0001};
        vecs[5] = '{4'hC, 32'h89ABCDEF, 4'h6, 128'h33ABCD33_22222222_11111111_00000000, 4'b1000};

        rst = 1'b1; load_valid = 1'b0; load_line = '0; wr_valid = 1'b0; wr_sel = '0;
        wr_data = '0; wr_be = '0; flush = 1'b0; line_ready = 1'b0;

        // Reset state, with a consumer already asserting ready.
        line_ready = 1'b1;
        tick();
        tick();
        chk("rst_load_ready", load_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_line_valid", line_valid, 0);
        chk("rst_line_out", line_out, 0);
        chk("rst_line_dirty", line_dirty, 0);
        rst = 1'b0;
        line_ready = 1'b0;
        #1;
        chk("post_rst_load_ready", load_ready, 1);
        chk("post_rst_wr_ready", wr_ready, 0);

        // Flush with no writes.
        do_load(BASE);
        do_flush();
        do_drain("no_write", BASE, 4'b0000);

        for (int i = 0; i < 6; i++) begin
            do_load(BASE);
            do_write(vecs[i].sel, vecs[i].data, vecs[i].be, 1'b0);
            do_flush();
            do_drain($sformatf("vec%0d", i), vecs[i].exp_line, vecs[i].exp_dirty);
        end

        // Accumulating writes, ignored offset bits, load_valid ignored in MERGE.
        do_load(BASE);
        do_write(4'h8, 32'hAABBCCDD, 4'hF, 1'b0);
        do_write(4'h5, 32'h000000EE, 4'h1, 1'b0);
        load_valid = 1'b1;
        load_line  = {128{1'b1}};
        chk("merge_load_ready", load_ready, 0);
        do_write(4'hF, 32'h11112222, 4'hF, 1'b0);
        do_write(4'hC, 32'h99998888, 4'hF, 1'b0);
        load_valid = 1'b0;
        do_flush();
        do_drain("accum", 128'h99998888_AABBCCDD_111111EE_00000000, 4'b1110);

        // Write together with flush, then a stalled consumer while inputs try to disturb it.
        do_load(BASE);
        do_write(4'h4, 32'hCAFEBABE, 4'hF, 1'b1);
        for (int c = 0; c < 5; c++) begin
            wr_valid = 1'b1; wr_sel = 4'h0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
            flush = 1'b1; load_valid = 1'b1;
            chk($sformatf("stall%0d_valid", c), line_valid, 1);
            chk($sformatf("stall%0d_wr_ready", c), wr_ready, 0);
            chk($sformatf("stall%0d_load_ready", c), load_ready, 0);
            chk($sformatf("stall%0d_line", c), line_out, 128'h33333333_22222222_CAFEBABE_00000000);
            chk($sformatf("stall%0d_dirty", c), line_dirty, 4'b0010);
            tick();
        end
        wr_valid = 1'b0; wr_be = 4'h0; flush = 1'b0; load_valid = 1'b0;
        do_drain("stall", 128'h33333333_22222222_CAFEBABE_00000000, 4'b0010);

        // Reset while the line is waiting to drain.
        do_load(BASE);
        do_write(4'h0, 32'h01020304, 4'hF, 1'b1);
        chk("pre_rst_valid", line_valid, 1);
        rst = 1'b1;
        line_ready = 1'b1;
        #1;
        chk("rst_drain_valid_gated", line_valid, 0);
        tick();
        chk("rst_drain_valid", line_valid, 0);
        chk("rst_drain_load_ready", load_ready, 0);
        rst = 1'b0;
        line_ready = 1'b0;
        #1;
        chk("rst_drain_load_ready_after", load_ready, 1);
        chk("rst_drain_line", line_out, 0);
        chk("rst_drain_dirty", line_dirty, 0);

        // Random sessions against the byte-array model.
        for (int s = 0; s < 150; s++) begin
            logic [127:0] l;
            logic [3:0]   sel;
            logic [31:0]  data;
            logic [3:0]   be;
            logic         last;
            logic         fl_with;
            logic         pre;
            int           nw;
            int           widx;
            l = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int b = 0; b < 16; b++) mb[b] = l[b*8 +: 8];
            md = 4'h0;
            do_load(l);
            nw = $urandom_range(0, 6);
            fl_with = 1'b0;
            for (int i = 0; i < nw; i++) begin
                if ($urandom_range(0, 2) == 0) tick();
                sel  = 4'($urandom_range(0, 15));
                data = $urandom();
                be   = 4'($urandom_range(0, 15));
                last = (i == nw - 1) && ($urandom_range(0, 1) == 1);
                widx = int'(sel) / 4;
                for (int k = 0; k < 4; k++) begin
                    if (be[k]) mb[widx*4 + k] = data[k*8 +: 8];
                end
                if (be != 4'h0) md[widx] = 1'b1;
                do_write(sel, data, be, last);
                if (last) fl_with = 1'b1;
            end
            pre = 1'($urandom_range(0, 1));
            line_ready = pre;
            if (!fl_with) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end
            chk($sformatf("rnd%0d_valid", s), line_valid, 1);
            chk($sformatf("rnd%0d_line", s), line_out, model_line());
            chk($sformatf("rnd%0d_dirty", s), line_dirty, md);
            if (!pre) begin
                repeat ($urandom_range(0, 3)) tick();
                chk($sformatf("rnd%0d_line_held", s), line_out, model_line());
                line_ready = 1'b1;
            end
            tick();
            line_ready = 1'b0;
            chk($sformatf("rnd%0d_load_ready", s), load_ready, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
